// File: rtl/run_dump_ctrl.sv
// Run/dump controller: lets a CPU execute until a halt instruction or a cycle
// budget runs out, then streams r0-r7 and m0-m31 out over a valid/ready port.
module run_dump_ctrl #(
    parameter int          MAX_CYCLES = 200,
    parameter int          DATA_W     = 16,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [15:0]       instr_i,
    output logic              pc_en_o,
    output logic [2:0]        rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [4:0]        dm_addr_o,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [5:0]        dump_idx_o,
    output logic [15:0]       cycle_cnt_o,
    output logic              done_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] LP_LAST_CYCLE = 16'(MAX_CYCLES - 1);
    localparam logic [5:0]  LP_LAST_IDX   = 6'd39;
    localparam logic [5:0]  LP_RF_WORDS   = 6'd8;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cycle_cnt;
    logic [15:0] w_cycle_cnt_nxt;
    logic        r_timeout;
    logic        w_timeout_nxt;
    logic [5:0]  r_dump_idx;
    logic [5:0]  w_dump_idx_nxt;
    logic        r_dump_valid;
    logic        w_dump_valid_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_halt;
    logic        w_pc_en;
    logic        w_xfer;

    // Decode of the fetched instruction and the dump handshake.
    always_comb begin
        w_halt = (instr_i == HALT_INSTR);
        w_xfer = r_dump_valid && dump_ready_i;
    end

    // Next-state and next-value logic; pc_en is the only Mealy output.
    always_comb begin
        w_state_nxt      = r_state;
        w_cycle_cnt_nxt  = r_cycle_cnt;
        w_timeout_nxt    = r_timeout;
        w_dump_idx_nxt   = r_dump_idx;
        w_dump_valid_nxt = r_dump_valid;
        w_done_nxt       = r_done;
        w_pc_en          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_halt) begin
                    // Halt wins over the budget check: nothing executes or counts.
                    w_state_nxt      = ST_DUMP;
                    w_dump_idx_nxt   = 6'd0;
                    w_dump_valid_nxt = 1'b1;
                end else begin
                    w_pc_en = 1'b1;
                    if (r_cycle_cnt != 16'hFFFF) begin
                        w_cycle_cnt_nxt = r_cycle_cnt + 16'd1;
                    end else begin
                        w_cycle_cnt_nxt = r_cycle_cnt;
                    end
                    if (r_cycle_cnt == LP_LAST_CYCLE) begin
                        w_state_nxt      = ST_DUMP;
                        w_timeout_nxt    = 1'b1;
                        w_dump_idx_nxt   = 6'd0;
                        w_dump_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_DUMP: begin
                if (w_xfer) begin
                    if (r_dump_idx == LP_LAST_IDX) begin
                        w_state_nxt      = ST_DONE;
                        w_dump_valid_nxt = 1'b0;
                        w_done_nxt       = 1'b1;
                    end else begin
                        w_dump_idx_nxt = r_dump_idx + 6'd1;
                    end
                end else begin
                    w_state_nxt = ST_DUMP;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_dump_valid_nxt = 1'b0;
                w_done_nxt       = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cycle_cnt  <= 16'd0;
            r_timeout    <= 1'b0;
            r_dump_idx   <= 6'd0;
            r_dump_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cycle_cnt  <= w_cycle_cnt_nxt;
            r_timeout    <= w_timeout_nxt;
            r_dump_idx   <= w_dump_idx_nxt;
            r_dump_valid <= w_dump_valid_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Debug read addresses follow the dump index; memory words start at index 8.
    always_comb begin
        rf_addr_o   = r_dump_idx[2:0];
        dm_addr_o   = r_dump_idx[4:0] - 5'd8;
        if (r_dump_idx < LP_RF_WORDS) begin
            dump_data_o = rf_data_i;
        end else begin
            dump_data_o = dm_data_i;
        end
        pc_en_o      = w_pc_en;
        dump_valid_o = r_dump_valid;
        dump_idx_o   = r_dump_idx;
        cycle_cnt_o  = r_cycle_cnt;
        done_o       = r_done;
        timeout_o    = r_timeout;
    end

endmodule
